// File: rtl/pulse_train_monitor.sv
// pulse_train_monitor
// Checks a pulse train against compile-time expected high width and period.
// Every complete cycle (rise to rise) is measured. Mismatches, stuck lines and
// lock status are reported.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no measurement running; waiting for a real 0->1 transition
// S_HIGH | line high inside a measured cycle; counting high width
// S_LOW  | line low after the high phase; next rise completes the period

module pulse_train_monitor #(
  parameter int EXP_DURATION = 2,
  parameter int EXP_PERIOD   = 3,
  parameter int LOCK_COUNT   = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_pulse,
  input  logic                 i_clr_err,
  output logic [CNT_WIDTH-1:0] o_high_width,
  output logic [CNT_WIDTH-1:0] o_period,
  output logic                 o_meas_valid,
  output logic                 o_mismatch,
  output logic                 o_timeout,
  output logic                 o_err_sticky,
  output logic                 o_locked,
  output logic [CNT_WIDTH-1:0] o_good_count
);

  // Elaboration-time parameter legality checks
  if (EXP_DURATION < 1 || EXP_DURATION >= EXP_PERIOD) begin : g_bad_duration
    $error("pulse_train_monitor: need 1 <= EXP_DURATION < EXP_PERIOD");
  end
  if (LOCK_COUNT < 1) begin : g_bad_lock
    $error("pulse_train_monitor: LOCK_COUNT must be >= 1");
  end
  if (longint'(2 * EXP_PERIOD) >= (longint'(1) << CNT_WIDTH)) begin : g_bad_width
    $error("pulse_train_monitor: 2*EXP_PERIOD must fit below 2**CNT_WIDTH");
  end
  if (longint'(LOCK_COUNT) >= (longint'(1) << CNT_WIDTH)) begin : g_bad_lock_width
    $error("pulse_train_monitor: LOCK_COUNT must fit in CNT_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0] EXP_DUR_C = CNT_WIDTH'(EXP_DURATION);
  localparam logic [CNT_WIDTH-1:0] EXP_PER_C = CNT_WIDTH'(EXP_PERIOD);
  localparam logic [CNT_WIDTH-1:0] TO_LIMIT  = CNT_WIDTH'(2 * EXP_PERIOD);
  localparam logic [CNT_WIDTH-1:0] LOCK_C    = CNT_WIDTH'(LOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0] ONE_C     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] ALL_ONES  = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;

  logic                 pulse_d;
  logic                 rise;
  logic                 fall;

  logic [CNT_WIDTH-1:0] hi_cnt;
  logic [CNT_WIDTH-1:0] per_cnt;
  logic [CNT_WIDTH-1:0] hi_cap;
  logic [CNT_WIDTH-1:0] good_run;
  logic [CNT_WIDTH-1:0] good_run_d;

  // Events decoded alongside the next-state logic
  logic                 start_evt;
  logic                 meas_evt;
  logic                 tmo_evt;
  logic                 cap_evt;

  logic                 mismatch_now;
  logic                 good_now;
  logic                 err_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == ALL_ONES) ? v : v + ONE_C;
  endfunction

  assign rise = i_pulse & ~pulse_d;
  assign fall = ~i_pulse & pulse_d;

  // Registered copy of the line; reset high so a line already high is no edge
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_d <= 1'b1;
    end else begin
      pulse_d <= i_pulse;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A completing rise in S_LOW beats the timeout, while in
  // S_IDLE the timeout wins and a rise on that edge is dropped.
  always_comb begin
    state_d   = state_q;
    start_evt = 1'b0;
    meas_evt  = 1'b0;
    tmo_evt   = 1'b0;
    cap_evt   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (per_cnt == TO_LIMIT) begin
          tmo_evt = 1'b1;
        end else if (rise) begin
          start_evt = 1'b1;
          state_d   = S_HIGH;
        end
      end
      S_HIGH: begin
        if (per_cnt == TO_LIMIT) begin
          tmo_evt = 1'b1;
        end else if (fall) begin
          cap_evt = 1'b1;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (rise) begin
          meas_evt  = 1'b1;
          start_evt = 1'b1;
          state_d   = S_HIGH;
        end else if (per_cnt == TO_LIMIT) begin
          tmo_evt = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (tmo_evt) begin
      state_d = S_IDLE;
    end
  end

  // Output decode: classify the completed period and derive lock/error updates
  always_comb begin
    mismatch_now = meas_evt && ((per_cnt != EXP_PER_C) || (hi_cap != EXP_DUR_C));
    good_now     = meas_evt && !mismatch_now;

    good_run_d = good_run;
    if (mismatch_now || tmo_evt) begin
      good_run_d = '0;
    end else if (good_now && (good_run != LOCK_C)) begin
      good_run_d = good_run + ONE_C;
    end

    err_d = o_err_sticky;
    if (i_clr_err) begin
      err_d = 1'b0;
    end
    if (mismatch_now || tmo_evt) begin
      err_d = 1'b1;
    end
  end

  // Width and period counters; per_cnt in S_IDLE only runs while the line is low
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_cnt  <= '0;
      per_cnt <= '0;
      hi_cap  <= '0;
    end else if (tmo_evt) begin
      hi_cnt  <= '0;
      per_cnt <= '0;
    end else if (start_evt) begin
      hi_cnt  <= ONE_C;
      per_cnt <= ONE_C;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!i_pulse) begin
            per_cnt <= sat_inc(per_cnt);
          end
        end
        S_HIGH: begin
          per_cnt <= sat_inc(per_cnt);
          if (i_pulse) begin
            hi_cnt <= sat_inc(hi_cnt);
          end
          if (cap_evt) begin
            hi_cap <= hi_cnt;
          end
        end
        S_LOW: begin
          per_cnt <= sat_inc(per_cnt);
        end
        default: begin
          per_cnt <= '0;
        end
      endcase
    end
  end

  // Registered outputs: strobes, measurements, lock and error status
  always_ff @(posedge clk) begin
    if (rst) begin
      o_high_width <= '0;
      o_period     <= '0;
      o_meas_valid <= 1'b0;
      o_mismatch   <= 1'b0;
      o_timeout    <= 1'b0;
      o_err_sticky <= 1'b0;
      o_locked     <= 1'b0;
      o_good_count <= '0;
      good_run     <= '0;
    end else begin
      o_meas_valid <= meas_evt;
      o_mismatch   <= mismatch_now;
      o_timeout    <= tmo_evt;
      if (meas_evt) begin
        o_period     <= per_cnt;
        o_high_width <= hi_cap;
      end
      good_run     <= good_run_d;
      o_locked     <= (good_run_d == LOCK_C);
      if (good_now) begin
        o_good_count <= sat_inc(o_good_count);
      end
      o_err_sticky <= err_d;
    end
  end

endmodule

// File: tb/tb_pulse_train_monitor.sv
// Testbench for pulse_train_monitor with default parameters (2/3/4/16).
module tb_pulse_train_monitor;

  logic        clk;
  logic        rst;
  logic        i_pulse;
  logic        i_clr_err;
  logic [15:0] o_high_width;
  logic [15:0] o_period;
  logic        o_meas_valid;
  logic        o_mismatch;
  logic        o_timeout;
  logic        o_err_sticky;
  logic        o_locked;
  logic [15:0] o_good_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic        pulse;
    logic        clr;
    logic        v;
    logic        m;
    logic        t;
    logic        l;
    logic        e;
    logic [15:0] hw;
    logic [15:0] per;
    logic [15:0] gc;
  } vec_t;

  vec_t vecs[$];

  pulse_train_monitor #(
    .EXP_DURATION(2),
    .EXP_PERIOD  (3),
    .LOCK_COUNT  (4),
    .CNT_WIDTH   (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_pulse     (i_pulse),
    .i_clr_err   (i_clr_err),
    .o_high_width(o_high_width),
    .o_period    (o_period),
    .o_meas_valid(o_meas_valid),
    .o_mismatch  (o_mismatch),
    .o_timeout   (o_timeout),
    .o_err_sticky(o_err_sticky),
    .o_locked    (o_locked),
    .o_good_count(o_good_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic row(input logic r, input logic p, input logic c,
                     input logic v, input logic m, input logic t,
                     input logic l, input logic e,
                     input int hw, input int per, input int gc);
    vec_t x;
    x.rst = r; x.pulse = p; x.clr = c;
    x.v = v; x.m = m; x.t = t; x.l = l; x.e = e;
    x.hw = 16'(hw); x.per = 16'(per); x.gc = 16'(gc);
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic p);
    i_pulse = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    i_pulse   = 1'b0;
    i_clr_err = 1'b0;

    // rst p clr | v m t l e | hw per gc
    // reset, then a clean 2/3 train up to lock
    row(1,0,0, 0,0,0, 0,0, 0,0,0);
    row(1,0,0, 0,0,0, 0,0, 0,0,0);
    row(0,0,0, 0,0,0, 0,0, 0,0,0);
    row(0,1,0, 0,0,0, 0,0, 0,0,0);
    row(0,1,0, 0,0,0, 0,0, 0,0,0);
    row(0,0,0, 0,0,0, 0,0, 0,0,0);
    row(0,1,0, 1,0,0, 0,0, 2,3,1);
    row(0,1,0, 0,0,0, 0,0, 2,3,1);
    row(0,0,0, 0,0,0, 0,0, 2,3,1);
    row(0,1,0, 1,0,0, 0,0, 2,3,2);
    row(0,1,0, 0,0,0, 0,0, 2,3,2);
    row(0,0,0, 0,0,0, 0,0, 2,3,2);
    row(0,1,0, 1,0,0, 0,0, 2,3,3);
    row(0,1,0, 0,0,0, 0,0, 2,3,3);
    row(0,0,0, 0,0,0, 0,0, 2,3,3);
    row(0,1,0, 1,0,0, 1,0, 2,3,4);
    // 3 high / 2 low period: mismatch drops lock
    row(0,1,0, 0,0,0, 1,0, 2,3,4);
    row(0,1,0, 0,0,0, 1,0, 2,3,4);
    row(0,0,0, 0,0,0, 1,0, 2,3,4);
    row(0,0,0, 0,0,0, 1,0, 2,3,4);
    row(0,1,0, 1,1,0, 0,1, 3,5,4);
    // four good periods relock, sticky error stays
    row(0,1,0, 0,0,0, 0,1, 3,5,4);
    row(0,0,0, 0,0,0, 0,1, 3,5,4);
    row(0,1,0, 1,0,0, 0,1, 2,3,5);
    row(0,1,0, 0,0,0, 0,1, 2,3,5);
    row(0,0,0, 0,0,0, 0,1, 2,3,5);
    row(0,1,0, 1,0,0, 0,1, 2,3,6);
    row(0,1,0, 0,0,0, 0,1, 2,3,6);
    row(0,0,0, 0,0,0, 0,1, 2,3,6);
    row(0,1,0, 1,0,0, 0,1, 2,3,7);
    row(0,1,0, 0,0,0, 0,1, 2,3,7);
    row(0,0,0, 0,0,0, 0,1, 2,3,7);
    row(0,1,0, 1,0,0, 1,1, 2,3,8);
    // stuck high: timeout 6 cycles after the last rise
    row(0,1,0, 0,0,0, 1,1, 2,3,8);
    row(0,1,0, 0,0,0, 1,1, 2,3,8);
    row(0,1,0, 0,0,0, 1,1, 2,3,8);
    row(0,1,0, 0,0,0, 1,1, 2,3,8);
    row(0,1,0, 0,0,0, 1,1, 2,3,8);
    row(0,1,0, 0,0,1, 0,1, 2,3,8);
    // resume: first valid on the second rise
    row(0,1,0, 0,0,0, 0,1, 2,3,8);
    row(0,0,0, 0,0,0, 0,1, 2,3,8);
    row(0,1,0, 0,0,0, 0,1, 2,3,8);
    row(0,1,0, 0,0,0, 0,1, 2,3,8);
    row(0,0,0, 0,0,0, 0,1, 2,3,8);
    row(0,1,0, 1,0,0, 0,1, 2,3,9);
    // clear alone, then clear together with a mismatch (set wins), then clear
    row(0,1,1, 0,0,0, 0,0, 2,3,9);
    row(0,0,0, 0,0,0, 0,0, 2,3,9);
    row(0,0,0, 0,0,0, 0,0, 2,3,9);
    row(0,1,1, 1,1,0, 0,1, 2,4,9);
    row(0,1,1, 0,0,0, 0,0, 2,4,9);
    row(0,0,0, 0,0,0, 0,0, 2,4,9);
    row(0,1,0, 1,0,0, 0,0, 2,3,10);
    // reset mid-HIGH: no strobe, clean reacquire
    row(0,1,0, 0,0,0, 0,0, 2,3,10);
    row(1,0,0, 0,0,0, 0,0, 0,0,0);
    row(0,0,0, 0,0,0, 0,0, 0,0,0);
    row(0,1,0, 0,0,0, 0,0, 0,0,0);
    row(0,1,0, 0,0,0, 0,0, 0,0,0);
    row(0,0,0, 0,0,0, 0,0, 0,0,0);
    row(0,1,0, 1,0,0, 0,0, 2,3,1);
    // line high through reset and after release: no edge until 0->1
    row(1,1,0, 0,0,0, 0,0, 0,0,0);
    row(1,1,0, 0,0,0, 0,0, 0,0,0);
    row(0,1,0, 0,0,0, 0,0, 0,0,0);
    row(0,1,0, 0,0,0, 0,0, 0,0,0);
    row(0,1,0, 0,0,0, 0,0, 0,0,0);
    row(0,0,0, 0,0,0, 0,0, 0,0,0);
    row(0,1,0, 0,0,0, 0,0, 0,0,0);
    row(0,1,0, 0,0,0, 0,0, 0,0,0);
    row(0,0,0, 0,0,0, 0,0, 0,0,0);
    row(0,1,0, 1,0,0, 0,0, 2,3,1);
    // stuck low in LOW, then in IDLE; rise on the IDLE timeout edge is dropped
    row(0,0,0, 0,0,0, 0,0, 2,3,1);
    row(0,0,0, 0,0,0, 0,0, 2,3,1);
    row(0,0,0, 0,0,0, 0,0, 2,3,1);
    row(0,0,0, 0,0,0, 0,0, 2,3,1);
    row(0,0,0, 0,0,0, 0,0, 2,3,1);
    row(0,0,0, 0,0,1, 0,1, 2,3,1);
    row(0,0,0, 0,0,0, 0,1, 2,3,1);
    row(0,0,0, 0,0,0, 0,1, 2,3,1);
    row(0,0,0, 0,0,0, 0,1, 2,3,1);
    row(0,0,0, 0,0,0, 0,1, 2,3,1);
    row(0,0,0, 0,0,0, 0,1, 2,3,1);
    row(0,0,0, 0,0,0, 0,1, 2,3,1);
    row(0,1,0, 0,0,1, 0,1, 2,3,1);
    row(0,1,0, 0,0,0, 0,1, 2,3,1);
    row(0,0,0, 0,0,0, 0,1, 2,3,1);
    row(0,1,0, 0,0,0, 0,1, 2,3,1);
    row(0,1,0, 0,0,0, 0,1, 2,3,1);
    row(0,0,0, 0,0,0, 0,1, 2,3,1);
    row(0,1,0, 1,0,0, 0,1, 2,3,2);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst       = vecs[i].rst;
      i_pulse   = vecs[i].pulse;
      i_clr_err = vecs[i].clr;
      @(posedge clk);
      #1;
      total++;
      if ({o_meas_valid, o_mismatch, o_timeout, o_locked, o_err_sticky,
           o_high_width, o_period, o_good_count} !==
          {vecs[i].v, vecs[i].m, vecs[i].t, vecs[i].l, vecs[i].e,
           vecs[i].hw, vecs[i].per, vecs[i].gc}) begin
        bad++;
        $display("FAIL vec%0d: got v=%b m=%b t=%b l=%b e=%b hw=%0d per=%0d gc=%0d expected v=%b m=%b t=%b l=%b e=%b hw=%0d per=%0d gc=%0d",
                 i, o_meas_valid, o_mismatch, o_timeout, o_locked, o_err_sticky,
                 o_high_width, o_period, o_good_count,
                 vecs[i].v, vecs[i].m, vecs[i].t, vecs[i].l, vecs[i].e,
                 vecs[i].hw, vecs[i].per, vecs[i].gc);
      end
      @(negedge clk);
    end

    // Period of exactly 2*EXP_PERIOD: the completing rise wins over timeout
    step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    check("p6_valid",    int'(o_meas_valid), 1);
    check("p6_mismatch", int'(o_mismatch),   1);
    check("p6_timeout",  int'(o_timeout),    0);
    check("p6_period",   int'(o_period),     6);
    check("p6_width",    int'(o_high_width), 2);

    // Stuck high from here: bounded wait for the timeout strobe
    begin
      int  n;
      bit  seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
        step(1'b1);
        n++;
        if (o_timeout) seen = 1'b1;
      end
      check("stuck_hi_seen",   int'(seen), 1);
      check("stuck_hi_cycles", n,          6);
      check("stuck_hi_locked", int'(o_locked),     0);
      check("stuck_hi_err",    int'(o_err_sticky), 1);
      step(1'b1);
      check("timeout_one_cycle", int'(o_timeout), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pulse_train_monitor.md
Name: pulse_train_monitor

Overview:
- Downstream checker for the pulse generator output, normally wired to its o_pulse.
- Measures the high width and period of every complete pulse cycle and compares each against compile-time expected values.
- Flags mismatches and a stuck line, and reports lock once the pulse train is stable.
- Used in benches and in-system as a self-check of the pulse generation stage.

Parameters:
- EXP_DURATION, 2: expected high width in clk cycles. Legal range is 1 <= EXP_DURATION < EXP_PERIOD; elaboration $error otherwise.
- EXP_PERIOD, 3: expected period in clk cycles, measured rising edge to rising edge.
- LOCK_COUNT, 4: consecutive matching periods required before o_locked asserts. Must be >= 1.
- CNT_WIDTH, 16: width of all counters and measurement outputs. 2*EXP_PERIOD must be < 2**CNT_WIDTH.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_pulse  in  1  pulse train, synchronous to clk. No synchronizer.
- i_clr_err  in  1  clears o_err_sticky.
- o_high_width  out  CNT_WIDTH  last measured high width.
- o_period  out  CNT_WIDTH  last measured period.
- o_meas_valid  out  1  one-cycle strobe; the measurement outputs have just updated.
- o_mismatch  out  1  one-cycle strobe, coincident with o_meas_valid, when the measurement differs from expected.
- o_timeout  out  1  one-cycle strobe; no complete period within 2*EXP_PERIOD cycles.
- o_err_sticky  out  1  latched error flag.
- o_locked  out  1  LOCK_COUNT consecutive good periods seen.
- o_good_count  out  CNT_WIDTH  total matching periods; saturates at all-ones.

Behaviour:
- Reset (while rst=1 at a clk edge):
  - all outputs 0; state IDLE; counters 0.
  - pulse_d, the registered copy of i_pulse, is reset to 1, so a line already high at reset release is not taken as a rising edge.
- Edge detect, on the sampled value at each edge:
  - rise = i_pulse & ~pulse_d
  - fall = ~i_pulse & pulse_d
- FSM states: IDLE, HIGH, LOW.
- IDLE:
  - on rise: hi_cnt=1, per_cnt=1, go to HIGH.
  - otherwise per_cnt increments while i_pulse=0 (used for timeout only).
- HIGH:
  - i_pulse=1: hi_cnt++, per_cnt++.
  - fall: hi_cap<=hi_cnt, per_cnt++, go to LOW.
- LOW:
  - i_pulse=0: per_cnt++.
  - rise (period complete), all in the same edge:
    - o_period<=per_cnt; o_high_width<=hi_cap; o_meas_valid<=1.
    - o_mismatch<=(per_cnt!=EXP_PERIOD)||(hi_cap!=EXP_DURATION).
    - restart: hi_cnt=1, per_cnt=1, stay in HIGH path (go to HIGH).
- Latency: rise sampled at edge k; o_meas_valid is high in the cycle after edge k, for exactly one cycle.
- First period: the first rise after reset or timeout only starts measurement. No o_meas_valid until the second rise.
- Timeout:
  - in any state, when per_cnt reaches 2*EXP_PERIOD with no completing rise: o_timeout<=1 for one cycle, go to IDLE, per_cnt=0.
  - covers a line stuck high or stuck low.
  - a rise on the timeout edge is ignored; the next 0->1 restarts measurement.
- Lock:
  - good_run counts consecutive matching periods, saturating at LOCK_COUNT.
  - o_locked=1 while good_run==LOCK_COUNT.
  - a mismatch or timeout clears good_run and o_locked in the same edge.
- o_good_count increments on each matching period and saturates at 2**CNT_WIDTH-1.
- o_err_sticky:
  - set on mismatch or timeout.
  - cleared by i_clr_err or rst.
  - if set and clear happen on the same edge, set wins.
- Counters saturate and never wrap; the timeout guarantees this under the legal parameter range.
- Reset mid-period: measurement is abandoned with no strobe. The monitor then waits for a fresh 0->1 transition.

Test Plan:
1. Generator at DURATION=2, PERIOD=3 driving i_pulse after rst release -> o_meas_valid every 3 cycles starting at the second rise; o_high_width=2; o_period=3; o_mismatch=0; o_locked=1 after the 4th valid; o_good_count increments by 1 per valid.
2. Directed pattern with 3 cycles high, 2 low -> o_meas_valid with o_high_width=3, o_period=5, o_mismatch=1; o_locked drops and o_err_sticky=1. Afterwards, 4 correct 2/3 periods -> o_locked=1 again while o_err_sticky stays 1.
3. i_pulse held high after lock -> o_timeout strobes 6 cycles after the last rise; state returns to IDLE; o_locked=0. Resuming the 2/3 train -> first o_meas_valid at the second rise.
4. i_pulse=1 throughout reset and released high -> no measurement until a real 0->1 edge. The first o_meas_valid is one full period after that edge.
5. rst asserted for 1 cycle mid-HIGH -> all outputs 0 next cycle, no strobe; correct re-acquisition afterwards.
6. i_clr_err asserted on the same edge as a mismatch strobe -> o_err_sticky stays 1. i_clr_err alone one cycle later -> o_err_sticky=0.
